// File: rtl/div_mult_unit.sv
// div_mult_unit: iterative WIDTH-cycle signed mult/div loading HI/LO; MULTU/DIVU enabled by DIVMULT_UNSIGNED_EN
module div_mult_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic sgn, is_div, neg_q, neg_r, dz, last, zero_req;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mb, r, q;
  logic [WIDTH:0] sum, shl, diff;
  logic [2*WIDTH-1:0] prod;
`ifdef DIVMULT_UNSIGNED_EN
  assign sgn = ~op[1];
`else
  logic unused_op;
  assign unused_op = op[1];
  assign sgn = 1'b1;
`endif
  assign last = cnt == CNT_W'(WIDTH);
  assign zero_req = op[0] && b == {WIDTH{1'b0}};
  assign sum = {1'b0, r} + {1'b0, q[0] ? mb : {WIDTH{1'b0}}};
  assign shl = {r, q[WIDTH-1]};
  assign diff = shl - {1'b0, mb};
  assign prod = neg_q ? -{r, q} : {r, q};
  always_ff @(posedge clk) state <= !reset ? IDLE : state_nxt;
  always_comb state_nxt = state == IDLE ? (start ? (zero_req ? DONE : RUN) : IDLE) :
                          state == RUN  ? (last ? DONE : RUN) : IDLE;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    div_zero = done && dz;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      {is_div, dz, neg_q, neg_r} <= '0;
      {mb, r, q, hi, lo} <= '0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      is_div <= op[0];
      dz <= zero_req;
      neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sgn && a[WIDTH-1];
      mb <= sgn && b[WIDTH-1] ? -b : b;
      q <= sgn && a[WIDTH-1] ? -a : a;
      r <= '0;
      cnt <= '0;
    end else if (state == RUN && !last) begin
      cnt <= cnt + CNT_W'(1);
      r <= is_div ? (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
      q <= is_div ? {q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
    end else if (state == RUN) begin
      hi <= is_div ? (neg_r ? -r : r) : prod[2*WIDTH-1:WIDTH];
      lo <= is_div ? (neg_q ? -q : q) : prod[WIDTH-1:0];
    end
  end
endmodule
